// File: rtl/axis_traffic_gen.sv
// AXI-Stream traffic generator: emits packets of counter or LFSR data
// with byte-accurate tkeep and tlast.
module axis_traffic_gen #(
    parameter int          DATA_WIDTH = 32,
    parameter int          LEN_WIDTH  = 16,
    parameter int          CNT_WIDTH  = 16,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_mode,
    input  logic [LEN_WIDTH-1:0]    i_pkt_len,
    input  logic [CNT_WIDTH-1:0]    i_pkt_count,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int WORDS = DATA_WIDTH / 32;
    localparam int SH    = $clog2(BYTES);
    localparam int WSH   = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] beat_q, beat_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] pkt_q, pkt_d;
    logic [31:0]          n_q, n_d;
    logic [31:0]          lfsr_q, lfsr_d;

    logic [LEN_WIDTH-1:0] beats;
    logic [SH-1:0]        rem;
    logic [31:0]          lfsr_nxt;
    logic [31:0]          base;
    logic                 last_beat;
    logic                 fire;

    // Split the ceiling so a maximal length cannot overflow the counter
    assign rem       = len_q[SH-1:0];
    assign beats     = (len_q >> SH) + LEN_WIDTH'(rem != '0);
    assign last_beat = (beat_q == beats - LEN_WIDTH'(1));
    assign lfsr_nxt  = {lfsr_q[30:0],
                        lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    assign base      = n_q << WSH;

    assign m_axis_tvalid = (state_q == SEND);
    assign fire          = m_axis_tvalid & m_axis_tready;
    assign o_busy        = (state_q != IDLE);
    assign o_done        = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        pkt_d   = pkt_q;
        n_d     = n_q;
        lfsr_d  = lfsr_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    mode_d  = i_mode;
                    len_d   = i_pkt_len;
                    cnt_d   = i_pkt_count;
                    beat_d  = '0;
                    pkt_d   = '0;
                    n_d     = '0;
                    lfsr_d  = LFSR_SEED;
                    state_d = (i_pkt_len == '0 || i_pkt_count == '0)
                              ? DONE : SEND;
                end
            end
            SEND: begin
                if (fire) begin
                    n_d    = n_q + 32'd1;
                    lfsr_d = lfsr_nxt;
                    if (last_beat) begin
                        beat_d = '0;
                        if (pkt_q == cnt_q - CNT_WIDTH'(1)) begin
                            state_d = DONE;
                        end else begin
                            pkt_d = pkt_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        beat_d = beat_q + LEN_WIDTH'(1);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Beat outputs derive only from registers, so they hold during stalls
    always_comb begin
        m_axis_tdata = '0;
        m_axis_tkeep = '0;
        m_axis_tlast = 1'b0;
        if (m_axis_tvalid) begin
            for (int j = 0; j < WORDS; j++) begin
                m_axis_tdata[j*32 +: 32] = mode_q ? (lfsr_q ^ 32'(j))
                                                  : (base + 32'(j));
            end
            for (int b = 0; b < BYTES; b++) begin
                m_axis_tkeep[b] = !last_beat || (rem == '0)
                                  || (b < int'(rem));
            end
            m_axis_tlast = last_beat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            beat_q  <= '0;
            pkt_q   <= '0;
            n_q     <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            pkt_q   <= pkt_d;
            n_q     <= n_d;
            lfsr_q  <= lfsr_d;
        end
    end

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Bench for axis_traffic_gen: 32- and 64-bit instances on shared stimulus,
// checked against a packet-level reference model.
module tb_axis_traffic_gen;

    localparam logic [31:0] SEED = 32'hACE1_0001;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst, start, mode, tready;
    logic [15:0] len, cnt;

    logic        busy32, done32, tl32, tv32;
    logic [31:0] td32;
    logic [3:0]  tk32;
    logic        busy64, done64, tl64, tv64;
    logic [63:0] td64;
    logic [7:0]  tk64;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int done_cnt32 = 0, done_cnt64 = 0, done_cyc32 = 0, last_cyc32 = 0;
    int viol32 = 0, viol64 = 0;
    int i32, i64, d32, d64, v32, v64;

    beat_t q32[$], q64[$];
    beat_t cur32, pb32, cur64, pb64;
    logic  pv32 = 1'b0, pv64 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    axis_traffic_gen #(.DATA_WIDTH(32)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
        .i_pkt_len(len), .i_pkt_count(cnt),
        .o_busy(busy32), .o_done(done32),
        .m_axis_tdata(td32), .m_axis_tkeep(tk32), .m_axis_tlast(tl32),
        .m_axis_tvalid(tv32), .m_axis_tready(tready)
    );

    axis_traffic_gen #(.DATA_WIDTH(64)) dut64 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
        .i_pkt_len(len), .i_pkt_count(cnt),
        .o_busy(busy64), .o_done(done64),
        .m_axis_tdata(td64), .m_axis_tkeep(tk64), .m_axis_tlast(tl64),
        .m_axis_tvalid(tv64), .m_axis_tready(tready)
    );

    // tready: 0 = always ready, 1 = random, 2 = never ready
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            tready = (rdy_mode == 0) ? 1'b1 :
                     (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    always @(negedge clk) begin
        cur32 = '{d: 128'(td32), k: 16'(tk32), l: tl32};
        if (rst) begin
            pv32 = 1'b0;
        end else begin
            if (pv32 && (!tv32 || cur32 != pb32)) viol32++;
            if (!tv32 && cur32 != '0) viol32++;
            if (tv32 && tready) begin
                q32.push_back(cur32);
                last_cyc32 = cyc;
            end
            if (done32) begin
                done_cnt32++;
                done_cyc32 = cyc;
            end
            pv32 = tv32 && !tready;
            pb32 = cur32;
        end
    end

    always @(negedge clk) begin
        cur64 = '{d: 128'(td64), k: 16'(tk64), l: tl64};
        if (rst) begin
            pv64 = 1'b0;
        end else begin
            if (pv64 && (!tv64 || cur64 != pb64)) viol64++;
            if (!tv64 && cur64 != '0) viol64++;
            if (tv64 && tready) q64.push_back(cur64);
            if (done64) done_cnt64++;
            pv64 = tv64 && !tready;
            pb64 = cur64;
        end
    end

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    // Reference: expected beat stream for a whole transfer
    task automatic check_stream(string tag, int dw, bit m, int l, int c,
                                int off, input beat_t got[$]);
        int bytes = dw / 8;
        int words = dw / 32;
        int bpp   = (l + bytes - 1) / bytes;
        int rem   = l % bytes;
        int n     = 0;
        logic [31:0] lf = SEED;
        beat_t e;
        chk($sformatf("%s_w%0d_beats", tag, dw), got.size() - off, c * bpp);
        for (int p = 0; p < c; p++) begin
            for (int b = 0; b < bpp; b++) begin
                e = '0;
                for (int j = 0; j < words; j++) begin
                    e.d[j*32 +: 32] = m ? (lf ^ 32'(j))
                                        : 32'(n * words + j);
                end
                e.l = (b == bpp - 1);
                e.k = (e.l && rem != 0) ? 16'((1 << rem) - 1)
                                        : 16'((1 << bytes) - 1);
                if (off + n < got.size()) begin
                    chk($sformatf("%s_w%0d_data%0d", tag, dw, n),
                        got[off+n].d, e.d);
                    chk($sformatf("%s_w%0d_keep%0d", tag, dw, n),
                        128'(got[off+n].k), 128'(e.k));
                    chk($sformatf("%s_w%0d_last%0d", tag, dw, n),
                        128'(got[off+n].l), 128'(e.l));
                end
                n++;
                lf = lfsr_step(lf);
            end
        end
    endtask

    task automatic begin_xfer(bit m, int l, int c);
        i32 = q32.size();
        i64 = q64.size();
        d32 = done_cnt32;
        d64 = done_cnt64;
        v32 = viol32;
        v64 = viol64;
        mode = m;
        len = 16'(l);
        cnt = 16'(c);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_latency", 128'(busy32), 128'(1));
    endtask

    task automatic finish_xfer(string tag, bit m, int l, int c);
        int t = 0;
        while ((done_cnt32 == d32 || done_cnt64 == d64) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk({tag, "_timeout"}, 128'(t < 5000), 128'(1));
        check_stream(tag, 32, m, l, c, i32, q32);
        check_stream(tag, 64, m, l, c, i64, q64);
        chk({tag, "_stable32"}, 128'(viol32 - v32), 128'(0));
        chk({tag, "_stable64"}, 128'(viol64 - v64), 128'(0));
        chk({tag, "_done_once"}, 128'(done_cnt32 - d32), 128'(1));
        if (l > 0 && c > 0)
            chk({tag, "_done_timing"}, 128'(done_cyc32),
                128'(last_cyc32 + 1));
    endtask

    task automatic run(string tag, bit m, int l, int c);
        begin_xfer(m, l, c);
        finish_xfer(tag, m, l, c);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        len = '0;
        cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 128'(busy32), 128'(0));
        chk("rst_done", 128'(done32), 128'(0));
        chk("rst_tvalid", 128'(tv32), 128'(0));
        chk("rst_tlast", 128'(tl32), 128'(0));
        chk("rst_tdata", 128'(td32), 128'(0));
        chk("rst_tkeep", 128'(tk32), 128'(0));
        chk("rst_tvalid64", 128'(tv64), 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        run("cnt_8x2", 1'b0, 8, 2);
        run("cnt_10x1", 1'b0, 10, 1);
        run("lfsr_10x2", 1'b1, 10, 2);

        rdy_mode = 1;
        run("lfsr_rnd37", 1'b1, 37, 3);
        for (int i = 0; i < 4; i++) begin
            int l, c;
            bit m;
            l = $urandom_range(1, 60);
            c = $urandom_range(1, 4);
            m = 1'($urandom_range(0, 1));
            run($sformatf("rnd%0d", i), m, l, c);
        end
        rdy_mode = 0;
        @(posedge clk);
        #1;

        begin_xfer(1'b0, 0, 3);
        chk("len0_done", 128'(done32), 128'(1));
        chk("len0_tvalid", 128'(tv32), 128'(0));
        @(posedge clk);
        #1;
        chk("len0_busy_end", 128'(busy32), 128'(0));
        chk("len0_done_end", 128'(done32), 128'(0));
        begin_xfer(1'b0, 12, 0);
        chk("cnt0_done", 128'(done32), 128'(1));
        finish_xfer("cnt0", 1'b0, 12, 0);

        rdy_mode = 2;
        begin_xfer(1'b0, 12, 2);
        repeat (3) @(posedge clk);
        #1;
        mode = 1'b1;
        len = 16'd5;
        cnt = 16'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rdy_mode = 0;
        finish_xfer("start_busy", 1'b0, 12, 2);
        repeat (3) @(posedge clk);
        #1;
        chk("start_busy_idle", 128'(busy32), 128'(0));

        rdy_mode = 2;
        begin_xfer(1'b0, 16, 2);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_tvalid", 128'(tv32), 128'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_out32", 128'({busy32, done32, tv32, tl32, td32, tk32}),
            128'(0));
        chk("mid_rst_out64", 128'({busy64, done64, tv64, tl64, td64, tk64}),
            128'(0));
        rst = 1'b0;
        rdy_mode = 0;
        i32 = q32.size();
        d32 = done_cnt32;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_nobeats", 128'(q32.size() - i32), 128'(0));
        chk("mid_rst_nodone", 128'(done_cnt32 - d32), 128'(0));

        rst = 1'b1;
        start = 1'b1;
        len = 16'd8;
        cnt = 16'd1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        chk("rst_prio_busy", 128'(busy32), 128'(0));
        @(posedge clk);
        #1;
        chk("rst_prio_tvalid", 128'(tv32), 128'(0));

        run("post_rst_cnt", 1'b0, 8, 1);
        run("post_rst_lfsr", 1'b1, 12, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
